// File: rtl/tile_blitter.sv
// Sprite blitter: streams a w x h sprite from source ROM into the framebuffer,
// one pixel per cycle, dropping transparent and off-screen pixels.
module tile_blitter #(
    parameter int          FB_WIDTH    = 320,
    parameter int          FB_HEIGHT   = 240,
    parameter logic [7:0]  TRANSPARENT = 8'h00,
    parameter int          ROM_LAT     = 2
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [9:0]  x_in,
    input  logic [8:0]  y_in,
    input  logic [9:0]  w_in,
    input  logic [8:0]  h_in,
    input  logic [16:0] src_base_in,
    output logic [16:0] rom_addr_out,
    input  logic [7:0]  rom_data_in,
    output logic        fb_we_out,
    output logic [16:0] fb_addr_out,
    output logic [7:0]  fb_data_out,
    output logic        done_out,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [10:0] FB_W11     = 11'(FB_WIDTH);
    localparam logic [9:0]  FB_H10     = 10'(FB_HEIGHT);
    localparam logic [16:0] FB_W17     = 17'(FB_WIDTH);
    localparam logic [1:0]  DRAIN_LAST = 2'(ROM_LAT - 1);

    logic [1:0]  state;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic [9:0]  w_q;
    logic [8:0]  h_q;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [1:0]  drain_cnt;

    // Destination tag travelling alongside each ROM read.
    logic        dl_v  [ROM_LAT];
    logic        dl_in [ROM_LAT];
    logic [10:0] dl_x  [ROM_LAT];
    logic [9:0]  dl_y  [ROM_LAT];

    logic [10:0] cur_x;
    logic [9:0]  cur_y;
    logic        cur_in;
    logic        last_col;
    logic        last_row;

    // Handshake: a request transfers on any rising edge where req_valid_in and
    // req_ready_out are both high; ready is high only in IDLE, nothing is queued.
    assign req_ready_out = (state == S_IDLE);
    assign state_dbg     = state;

    assign cur_x    = {1'b0, x_q} + {1'b0, col};
    assign cur_y    = {1'b0, y_q} + {1'b0, row};
    assign cur_in   = (cur_x < FB_W11) && (cur_y < FB_H10);
    assign last_col = (col == w_q - 10'd1);
    assign last_row = (row == h_q - 9'd1);

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            state        <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            col          <= '0;
            row          <= '0;
            drain_cnt    <= '0;
            rom_addr_out <= '0;
            fb_we_out    <= 1'b0;
            fb_addr_out  <= '0;
            fb_data_out  <= '0;
            done_out     <= 1'b0;
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_v[i]  <= 1'b0;
                dl_in[i] <= 1'b0;
                dl_x[i]  <= '0;
                dl_y[i]  <= '0;
            end
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_in) begin
                        x_q <= x_in;
                        y_q <= y_in;
                        w_q <= w_in;
                        h_q <= h_in;
                        col <= '0;
                        row <= '0;
                        if (w_in == 10'd0 || h_in == 9'd0) begin
                            state    <= S_DONE;
                            done_out <= 1'b1;
                        end else begin
                            state        <= S_RUN;
                            rom_addr_out <= src_base_in;
                        end
                    end
                end
                S_RUN: begin
                    // The address stays on the final pixel so it holds outside RUN.
                    if (!(last_col && last_row))
                        rom_addr_out <= rom_addr_out + 17'd1;
                    if (last_col) begin
                        col <= '0;
                        if (last_row) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            row <= row + 9'd1;
                        end
                    end else begin
                        col <= col + 10'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= S_DONE;
                        done_out <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            dl_v[0]  <= (state == S_RUN);
            dl_in[0] <= cur_in;
            dl_x[0]  <= cur_x;
            dl_y[0]  <= cur_y;
            for (int i = 1; i < ROM_LAT; i++) begin
                dl_v[i]  <= dl_v[i-1];
                dl_in[i] <= dl_in[i-1];
                dl_x[i]  <= dl_x[i-1];
                dl_y[i]  <= dl_y[i-1];
            end

            if (dl_v[ROM_LAT-1] && dl_in[ROM_LAT-1] && rom_data_in != TRANSPARENT) begin
                fb_we_out   <= 1'b1;
                fb_addr_out <= 17'(dl_x[ROM_LAT-1]) + 17'(dl_y[ROM_LAT-1]) * FB_W17;
                fb_data_out <= rom_data_in;
            end else begin
                fb_we_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tile_blitter.sv
// Directed and randomized blits against a per-pixel reference model of the
// expected framebuffer writes, ROM addresses and completion timing.
module tb_tile_blitter;

    localparam int L    = 2;
    localparam int FB_W = 320;
    localparam int FB_H = 240;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  x_v;
    logic [8:0]  y_v;
    logic [9:0]  w_v;
    logic [8:0]  h_v;
    logic [16:0] base_v;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic        done;
    logic [1:0]  state_dbg;

    logic [7:0]  rom      [131072];
    logic [7:0]  rom_pipe [L];

    logic [24:0] exp_q[$];
    bit          exp_at[int];

    int          checks = 0;
    int          errors = 0;
    logic [16:0] rom_hold  = '0;
    logic [16:0] held_addr = '0;
    logic [7:0]  held_data = '0;

    tile_blitter #(
        .FB_WIDTH(FB_W), .FB_HEIGHT(FB_H), .TRANSPARENT(8'h00), .ROM_LAT(L)
    ) dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .req_valid_in (req_valid),
        .req_ready_out(req_ready),
        .x_in         (x_v),
        .y_in         (y_v),
        .w_in         (w_v),
        .h_in         (h_v),
        .src_base_in  (base_v),
        .rom_addr_out (rom_addr),
        .rom_data_in  (rom_data),
        .fb_we_out    (fb_we),
        .fb_addr_out  (fb_addr),
        .fb_data_out  (fb_data),
        .done_out     (done),
        .state_dbg    (state_dbg)
    );

    // Clock and ROM with an L-cycle read latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_pipe[0] <= rom[rom_addr];
        for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[L-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // Call just after a negedge with the DUT idle; returns at the negedge of
    // the first idle cycle after the blit.
    task automatic blit(input int x, input int y, input int w, input int h,
                        input int base, input bit keep);
        int n, t_end, k, sa, fa;
        logic [7:0]  px;
        logic [24:0] e;
        n = w * h;
        t_end = (n == 0) ? 2 : n + L + 2;
        exp_q.delete();
        exp_at.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                k  = r * w + c + 1;
                sa = (base + r * w + c) % 131072;
                px = rom[sa];
                if (x + c < FB_W && y + r < FB_H && px != 8'h00) begin
                    fa = (x + c) + (y + r) * FB_W;
                    exp_at[k + L + 1] = 1'b1;
                    exp_q.push_back({17'(fa), px});
                end
            end
        end
        x_v = 10'(x); y_v = 9'(y); w_v = 10'(w); h_v = 9'(h); base_v = 17'(base);
        req_valid = 1'b1;
        chk("ready_at_accept", {31'd0, req_ready}, 32'd1);
        for (int t = 1; t <= t_end; t++) begin
            @(negedge clk);
            chk("ready", {31'd0, req_ready}, {31'd0, t == t_end});
            chk("done", {31'd0, done}, {31'd0, t == t_end - 1});
            if (t <= n)
                chk("rom_addr", {15'd0, rom_addr}, 32'((base + t - 1) % 131072));
            else if (n > 0)
                chk("rom_addr_hold", {15'd0, rom_addr}, 32'((base + n - 1) % 131072));
            else
                chk("rom_addr_idle", {15'd0, rom_addr}, {15'd0, rom_hold});
            chk("fb_we", {31'd0, fb_we}, {31'd0, exp_at.exists(t)});
            if (exp_at.exists(t) && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                held_addr = e[24:8];
                held_data = e[7:0];
            end
            chk("fb_addr", {15'd0, fb_addr}, {15'd0, held_addr});
            chk("fb_data", {24'd0, fb_data}, {24'd0, held_data});
            if (t == t_end)
                chk("state_idle", {30'd0, state_dbg}, 32'd0);
            if (t == 1) req_valid = keep;
            if (t < t_end) begin
                // Busy-time input changes must be ignored.
                x_v = 10'($urandom); y_v = 9'($urandom); w_v = 10'($urandom); h_v = 9'($urandom);
            end
        end
        if (n > 0) rom_hold = 17'((base + n - 1) % 131072);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0;
        x_v = '0; y_v = '0; w_v = '0; h_v = '0; base_v = '0;
        for (int i = 0; i < 131072; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_we", {31'd0, fb_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rom_addr", {15'd0, rom_addr}, 32'd0);
        chk("rst_fb_addr", {15'd0, fb_addr}, 32'd0);
        chk("rst_fb_data", {24'd0, fb_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic blit, solid colour.
        for (int i = 100; i < 108; i++) rom[i] = 8'h05;
        blit(10, 20, 4, 2, 100, 1'b0);
        // Same blit with one transparent source pixel.
        rom[102] = 8'h00;
        blit(10, 20, 4, 2, 100, 1'b0);
        // Clipped at the bottom-right corner.
        for (int i = 0; i < 8; i++) rom[2000 + i] = 8'h3c;
        blit(318, 239, 4, 2, 2000, 1'b0);
        // Empty sprites.
        blit(5, 5, 0, 5, 300, 1'b0);
        blit(5, 5, 7, 0, 300, 1'b0);
        // ROM address wrap.
        blit(0, 0, 4, 1, 131070, 1'b0);
        // Back-to-back with valid held high.
        blit(50, 60, 3, 3, 4000, 1'b1);
        blit(52, 61, 5, 2, 4100, 1'b0);

        // Reset in the middle of a 16x16 blit, with a request on the reset edge.
        x_v = 10'd100; y_v = 9'd50; w_v = 10'd16; h_v = 9'd16; base_v = 17'd500;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_run_busy", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_we", {31'd0, fb_we}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rom_addr", {15'd0, rom_addr}, 32'd0);
        chk("abort_fb_addr", {15'd0, fb_addr}, 32'd0);
        chk("abort_fb_data", {24'd0, fb_data}, 32'd0);
        rst_n = 1'b1; req_valid = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            chk("post_abort_we", {31'd0, fb_we}, 32'd0);
            chk("post_abort_done", {31'd0, done}, 32'd0);
            chk("post_abort_ready", {31'd0, req_ready}, 32'd1);
        end
        rom_hold = '0; held_addr = '0; held_data = '0;
        blit(30, 40, 16, 16, 500, 1'b0);

        // Randomized blits, some clipped, some chained.
        for (int i = 0; i < 14; i++) begin
            int rx, ry;
            rx = ($urandom_range(0, 1) == 1) ? $urandom_range(300, 330) : $urandom_range(0, 1023);
            ry = ($urandom_range(0, 1) == 1) ? $urandom_range(220, 250) : $urandom_range(0, 511);
            blit(rx, ry, $urandom_range(0, 12), $urandom_range(0, 6),
                 $urandom_range(0, 131071), (i < 13) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
